// File: rtl/counter_pkg.sv
// Shared constants and the per-cycle operation selector for the up/down counter.
package counter_pkg;

  localparam int unsigned DEF_WIDTH       = 16;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned MODE_SATURATE   = 0;
  localparam int unsigned MODE_WRAP       = 1;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_INC  = 2'd2,
    OP_DEC  = 2'd3
  } op_e;

  // Priority: load > cnt_en > step pulses; opposing pulses cancel.
  function automatic op_e sel_op(input logic ld, input logic en,
                                 input logic up_p, input logic dn_p);
    if (ld)                return OP_LOAD;
    else if (en)           return OP_INC;
    else if (up_p && !dn_p) return OP_INC;
    else if (dn_p && !up_p) return OP_DEC;
    else                   return OP_HOLD;
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// Synchronizes an asynchronous button and emits a one-cycle pulse per rising edge.
module edge_pulse #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clkin,
  input  logic rst_n,
  input  logic async_i,
  output logic pulse_o
);

  localparam int unsigned LAST = SYNC_STAGES - 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   prev_q;
  logic                   armed_q;

  // fill_q marks when sync_q holds a genuine post-reset sample; arming needs
  // one real low sample so a button held through reset release never steps.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      fill_q  <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], async_i};
      fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q  <= sync_q[LAST];
      armed_q <= armed_q | (fill_q[LAST] & ~sync_q[LAST]);
    end
  end

  assign pulse_o = sync_q[LAST] & ~prev_q & armed_q;

endmodule

// File: rtl/updn_counter_p.sv
// Loadable up/down counter with level count enable, debounced-by-edge step
// buttons, wrap or saturate at the limits, and an overflow pulse.
module updn_counter_p
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned WRAP        = MODE_WRAP,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             cnt_en,
  input  logic             step_up,
  input  logic             step_dn,
  output logic [WIDTH-1:0] q,
  output logic             utc,
  output logic             dtc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam bit               WRAP_EN  = (WRAP == MODE_WRAP);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             up_p, dn_p;
  op_e              op;

  edge_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_up (
    .clkin   (clkin),
    .rst_n   (rst_n),
    .async_i (step_up),
    .pulse_o (up_p)
  );

  edge_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_dn (
    .clkin   (clkin),
    .rst_n   (rst_n),
    .async_i (step_dn),
    .pulse_o (dn_p)
  );

  assign op = sel_op(load, cnt_en, up_p, dn_p);

  // Next count; a limit crossing either wraps or is blocked, both flag ovf.
  always_comb begin
    q_d   = q_q;
    ovf_d = 1'b0;
    case (op)
      OP_LOAD: q_d = load_val;
      OP_INC: begin
        if (q_q == ALL_ONES) begin
          ovf_d = 1'b1;
          q_d   = WRAP_EN ? '0 : q_q;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end
      OP_DEC: begin
        if (q_q == '0) begin
          ovf_d = 1'b1;
          q_d   = WRAP_EN ? ALL_ONES : q_q;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign q   = q_q;
  assign ovf = ovf_q;
  assign utc = &q_q;
  assign dtc = ~|q_q;

endmodule

// File: tb/tb_updn_counter_p.sv
// Bench for updn_counter_p: a wrapping and a saturating instance driven in
// parallel, checked every cycle against an arithmetic model plus literals.
module tb_updn_counter_p;

  localparam int S = 2;

  logic        clkin = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = 16'h0;
  logic        cnt_en = 1'b0;
  logic        step_up = 1'b0;
  logic        step_dn = 1'b0;

  logic [15:0] q_w, q_s;
  logic        utc_w, utc_s, dtc_w, dtc_s, ovf_w, ovf_s;

  int n_err = 0;
  int n_chk = 0;

  // Model state: index 0 = wrapping instance, 1 = saturating instance.
  logic [15:0] mq [2] = '{16'h0, 16'h0};
  logic        movf [2] = '{1'b0, 1'b0};
  bit          uh [$];
  bit          dh [$];

  always #5 clkin = ~clkin;

  updn_counter_p #(.WIDTH(16), .WRAP(1), .SYNC_STAGES(S)) u_wrap (
    .clkin(clkin), .rst_n(rst_n), .load(load), .load_val(load_val),
    .cnt_en(cnt_en), .step_up(step_up), .step_dn(step_dn),
    .q(q_w), .utc(utc_w), .dtc(dtc_w), .ovf(ovf_w)
  );

  updn_counter_p #(.WIDTH(16), .WRAP(0), .SYNC_STAGES(S)) u_sat (
    .clkin(clkin), .rst_n(rst_n), .load(load), .load_val(load_val),
    .cnt_en(cnt_en), .step_up(step_up), .step_dn(step_dn),
    .q(q_s), .utc(utc_s), .dtc(dtc_s), .ovf(ovf_s)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a step happens S edges after a 0->1 between two post-reset samples.
  initial begin
    forever begin
      @(posedge clkin or negedge rst_n);
      if (!rst_n) begin
        uh.delete();
        dh.delete();
        for (int m = 0; m < 2; m++) begin
          mq[m]   = 16'h0;
          movf[m] = 1'b0;
        end
      end else begin
        int  e;
        bit  up_s, dn_s;
        int  nx, delta;
        uh.push_back(step_up);
        dh.push_back(step_dn);
        e    = uh.size();
        up_s = (e >= S + 2) && uh[e-S-1] && !uh[e-S-2];
        dn_s = (e >= S + 2) && dh[e-S-1] && !dh[e-S-2];
        for (int m = 0; m < 2; m++) begin
          movf[m] = 1'b0;
          if (load) begin
            mq[m] = load_val;
          end else if (cnt_en || (up_s != dn_s)) begin
            delta = (cnt_en || up_s) ? 1 : -1;
            nx    = int'(mq[m]) + delta;
            if (nx > 65535 || nx < 0) begin
              movf[m] = 1'b1;
              if (m == 0) mq[m] = 16'(nx & 65535);
            end else begin
              mq[m] = 16'(nx);
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clkin);
      chk("q_wrap",   q_w,          mq[0]);
      chk("utc_wrap", 16'(utc_w),   16'(mq[0] == 16'hFFFF));
      chk("dtc_wrap", 16'(dtc_w),   16'(mq[0] == 16'h0000));
      chk("ovf_wrap", 16'(ovf_w),   16'(movf[0]));
      chk("q_sat",    q_s,          mq[1]);
      chk("utc_sat",  16'(utc_s),   16'(mq[1] == 16'hFFFF));
      chk("dtc_sat",  16'(dtc_s),   16'(mq[1] == 16'h0000));
      chk("ovf_sat",  16'(ovf_s),   16'(movf[1]));
    end
  end

  initial begin
    repeat (3) @(negedge clkin);
    chk("rst_q",   q_w,        16'h0000);
    chk("rst_utc", 16'(utc_w), 16'h0);
    chk("rst_dtc", 16'(dtc_w), 16'h1);
    chk("rst_ovf", 16'(ovf_s), 16'h0);
    rst_n = 1'b1;

    // Load then count up to all-ones.
    @(negedge clkin); load = 1'b1; load_val = 16'h9034;
    @(negedge clkin); load = 1'b0; cnt_en = 1'b1;
    chk("load_9034", q_w, 16'h9034);
    repeat (16'h6FCB) @(negedge clkin);
    cnt_en = 1'b0;
    chk("cnt_q_w",   q_w,        16'hFFFF);
    chk("cnt_q_s",   q_s,        16'hFFFF);
    chk("cnt_utc",   16'(utc_w), 16'h1);
    chk("cnt_dtc",   16'(dtc_w), 16'h0);

    // One step_up at all-ones: visible two edges after the first sample.
    step_up = 1'b1;
    repeat (2) @(negedge clkin);
    chk("up_lat_q", q_w, 16'hFFFF);
    @(negedge clkin);
    chk("up_wrap_q",   q_w,        16'h0000);
    chk("up_wrap_utc", 16'(utc_w), 16'h0);
    chk("up_wrap_dtc", 16'(dtc_w), 16'h1);
    chk("up_wrap_ovf", 16'(ovf_w), 16'h1);
    chk("up_sat_q",    q_s,        16'hFFFF);
    chk("up_sat_ovf",  16'(ovf_s), 16'h1);
    @(negedge clkin);
    chk("ovf_drop_w", 16'(ovf_w), 16'h0);
    chk("ovf_drop_s", 16'(ovf_s), 16'h0);
    step_up = 1'b0;
    repeat (4) @(negedge clkin);

    // One step_dn at zero.
    load = 1'b1; load_val = 16'h0000;
    @(negedge clkin); load = 1'b0; step_dn = 1'b1;
    repeat (3) @(negedge clkin);
    chk("dn_wrap_q",   q_w,        16'hFFFF);
    chk("dn_wrap_utc", 16'(utc_w), 16'h1);
    chk("dn_sat_q",    q_s,        16'h0000);
    chk("dn_sat_ovf",  16'(ovf_s), 16'h1);
    step_dn = 1'b0;
    repeat (4) @(negedge clkin);

    // Held button counts once per press.
    load = 1'b1; load_val = 16'h0100;
    @(negedge clkin); load = 1'b0;
    step_up = 1'b1; #600;
    step_up = 1'b0; #200;
    step_up = 1'b1; #700;
    step_up = 1'b0;
    repeat (5) @(negedge clkin);
    chk("press2_w", q_w, 16'h0102);
    chk("press2_s", q_s, 16'h0102);

    // Simultaneous up and down cancel.
    step_up = 1'b1; step_dn = 1'b1;
    repeat (5) @(negedge clkin);
    step_up = 1'b0; step_dn = 1'b0;
    repeat (5) @(negedge clkin);
    chk("both_w", q_w, 16'h0102);
    chk("both_s", q_s, 16'h0102);

    // Counting across the top limit.
    load = 1'b1; load_val = 16'hFFF0;
    @(negedge clkin); load = 1'b0; cnt_en = 1'b1;
    repeat (20) @(negedge clkin);
    cnt_en = 1'b0;
    chk("cross_w", q_w, 16'h0004);
    chk("cross_s", q_s, 16'hFFFF);

    // Load beats cnt_en.
    load = 1'b1; cnt_en = 1'b1; load_val = 16'h1234;
    @(negedge clkin); load = 1'b0; cnt_en = 1'b0;
    chk("ld_pri_w", q_w, 16'h1234);
    chk("ld_pri_s", q_s, 16'h1234);

    // Reset mid-count with a button held through release.
    cnt_en = 1'b1; step_up = 1'b1;
    repeat (3) @(negedge clkin);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_q_w", q_w,        16'h0000);
    chk("arst_dtc", 16'(dtc_w), 16'h1);
    cnt_en = 1'b0;
    repeat (2) @(negedge clkin);
    rst_n = 1'b1;
    repeat (10) @(negedge clkin);
    chk("held_w", q_w, 16'h0000);
    chk("held_s", q_s, 16'h0000);
    step_up = 1'b0;
    repeat (3) @(negedge clkin);
    step_up = 1'b1;
    repeat (3) @(negedge clkin);
    chk("repress_w", q_w, 16'h0001);
    chk("repress_s", q_s, 16'h0001);
    step_up = 1'b0;
    repeat (2) @(negedge clkin);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
